// File: rtl/riscv_csrbus_pkg.sv
// Shared CSR bus definitions: field widths, funct3 encodings, FSM state codes,
// the registered command payload and the access-classification helpers.
package riscv_csrbus_pkg;

  localparam int unsigned CSR_W = 12;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned RS1_W = 5;

  // Zicsr funct3 encodings; 000 and 100 are not CSR accesses.
  localparam logic [F3_W-1:0] CSRRW  = 3'b001;
  localparam logic [F3_W-1:0] CSRRS  = 3'b010;
  localparam logic [F3_W-1:0] CSRRC  = 3'b011;
  localparam logic [F3_W-1:0] CSRRWI = 3'b101;
  localparam logic [F3_W-1:0] CSRRSI = 3'b110;
  localparam logic [F3_W-1:0] CSRRCI = 3'b111;

  // FSM state codes.
  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_FWD  = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP = 2'd2;

  // Registered request header, broadcast to every target.
  typedef struct packed {
    logic [F3_W-1:0]  funct3;
    logic [CSR_W-1:0] csr;
    logic [RS1_W-1:0] rs1;
  } csr_cmd_t;

  // Set/clear forms only modify the CSR when rs1 (or uimm) is non-zero.
  function automatic logic is_write(input logic [F3_W-1:0] funct3, input logic [RS1_W-1:0] rs1);
    logic wr;
    wr = 1'b0;
    case (funct3)
      CSRRW, CSRRWI:                wr = 1'b1;
      CSRRS, CSRRC, CSRRSI, CSRRCI: wr = (rs1 != RS1_W'(0));
      default:                      wr = 1'b0;
    endcase
    return wr;
  endfunction

  // csr[11:10] == 2'b11 marks the read-only CSR space.
  function automatic logic is_ro(input logic [CSR_W-1:0] csr);
    return (csr[11:10] == 2'b11);
  endfunction

  function automatic logic is_legal(input logic [F3_W-1:0] funct3);
    return (funct3[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/riscv_csrbus_decoder.sv
// CSR address decoder: compares csr against per-channel BASE/MASK pairs.
// Ports:
//   csr    - CSR address to decode
//   hit    - one bit per channel whose (csr & MASK) == BASE
//   sel    - index of the lowest hitting channel (0 when nothing hits)
//   no_hit - no channel claims csr
module riscv_csrbus_decoder
  import riscv_csrbus_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter logic [CHANNELS-1:0][CSR_W-1:0] BASE = {12'hB00, 12'h300},
  parameter logic [CHANNELS-1:0][CSR_W-1:0] MASK = {12'hF00, 12'hF00},
  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CSR_W-1:0]    csr,
  output logic [CHANNELS-1:0] hit,
  output logic [SEL_W-1:0]    sel,
  output logic                no_hit
);

  // Priority encode from the top down so the lowest index is written last.
  always_comb begin
    hit = '0;
    sel = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      hit[i] = ((csr & MASK[i]) == BASE[i]);
    end
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (hit[i]) sel = SEL_W'(i);
    end
    no_hit = ~|hit;
  end

endmodule

// File: rtl/riscv_csrbus_demux.sv
// Routes one CSR request from the core to one of CHANNELS CSR targets by
// address decode, and answers unmapped, illegal, read-only-write and
// timed-out accesses with an error response.
// Ports:
//   i_clk, i_rst_n                 - clock, synchronous active-low reset
//   up_valid/funct3/csr/rs1/rs1_value - request from the core (held until ready)
//   up_ready/rd_value/error        - one-cycle response pulse to the core
//   dn_valid[CHANNELS]             - per-target request valid (one-hot)
//   dn_funct3/csr/rs1/rs1_value    - registered request payload, broadcast
//   dn_ready/rd_value/error[CHANNELS] - per-target response
module riscv_csrbus_demux
  import riscv_csrbus_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned CHANNELS = 2,
  parameter logic [CHANNELS-1:0][CSR_W-1:0] BASE = {12'hB00, 12'h300},
  parameter logic [CHANNELS-1:0][CSR_W-1:0] MASK = {12'hF00, 12'hF00},
  parameter int unsigned TIMEOUT  = 16,
  parameter bit          RO_CHECK = 1'b1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           up_valid,
  input  logic [F3_W-1:0]                up_funct3,
  input  logic [CSR_W-1:0]               up_csr,
  input  logic [RS1_W-1:0]               up_rs1,
  input  logic [XLEN-1:0]                up_rs1_value,
  output logic                           up_ready,
  output logic [XLEN-1:0]                up_rd_value,
  output logic                           up_error,
  output logic [CHANNELS-1:0]            dn_valid,
  output logic [F3_W-1:0]                dn_funct3,
  output logic [CSR_W-1:0]               dn_csr,
  output logic [RS1_W-1:0]               dn_rs1,
  output logic [XLEN-1:0]                dn_rs1_value,
  input  logic [CHANNELS-1:0]            dn_ready,
  input  logic [CHANNELS-1:0][XLEN-1:0]  dn_rd_value,
  input  logic [CHANNELS-1:0]            dn_error
);

  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [ST_W-1:0]     state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  csr_cmd_t            cmd_q, cmd_d;
  logic [XLEN-1:0]     rs1_value_q, rs1_value_d;
  logic [CHANNELS-1:0] dn_valid_d;
  logic                up_ready_d;
  logic [XLEN-1:0]     up_rd_value_d;
  logic                up_error_d;

  logic [CHANNELS-1:0] dec_hit;
  logic [SEL_W-1:0]    dec_sel;
  logic                dec_no_hit;
  logic                reject_c;
  logic                timeout_c;

  // Decode straight off the incoming address so IDLE can route in one cycle.
  riscv_csrbus_decoder #(
    .CHANNELS (CHANNELS),
    .BASE     (BASE),
    .MASK     (MASK)
  ) u_decoder (
    .csr    (up_csr),
    .hit    (dec_hit),
    .sel    (dec_sel),
    .no_hit (dec_no_hit)
  );

  assign reject_c = dec_no_hit
                  || !is_legal(up_funct3)
                  || (RO_CHECK && is_ro(up_csr) && is_write(up_funct3, up_rs1));

  assign timeout_c = (TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT - 1));

  assign dn_funct3    = cmd_q.funct3;
  assign dn_csr       = cmd_q.csr;
  assign dn_rs1       = cmd_q.rs1;
  assign dn_rs1_value = rs1_value_q;

  // Next-state and next-output logic; response fields are zero unless entering RESP.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    timer_d       = timer_q;
    cmd_d         = cmd_q;
    rs1_value_d   = rs1_value_q;
    dn_valid_d    = dn_valid;
    up_ready_d    = 1'b0;
    up_rd_value_d = '0;
    up_error_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (up_valid) begin
          cmd_d.funct3 = up_funct3;
          cmd_d.csr    = up_csr;
          cmd_d.rs1    = up_rs1;
          rs1_value_d  = up_rs1_value;
          if (reject_c) begin
            state_d    = ST_RESP;
            up_ready_d = 1'b1;
            up_error_d = 1'b1;
          end else begin
            state_d    = ST_FWD;
            sel_d      = dec_sel;
            timer_d    = '0;
            dn_valid_d = CHANNELS'(1) << dec_sel;
          end
        end
      end

      ST_FWD: begin
        timer_d = timer_q + TMR_W'(1);
        // A ready on the final timeout cycle still completes normally.
        if (dn_ready[sel_q]) begin
          state_d       = ST_RESP;
          dn_valid_d    = '0;
          up_ready_d    = 1'b1;
          up_rd_value_d = dn_rd_value[sel_q];
          up_error_d    = dn_error[sel_q];
        end else if (timeout_c) begin
          state_d    = ST_RESP;
          dn_valid_d = '0;
          up_ready_d = 1'b1;
          up_error_d = 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d    = ST_IDLE;
        dn_valid_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      timer_q     <= '0;
      cmd_q       <= '0;
      rs1_value_q <= '0;
      dn_valid    <= '0;
      up_ready    <= 1'b0;
      up_rd_value <= '0;
      up_error    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      timer_q     <= timer_d;
      cmd_q       <= cmd_d;
      rs1_value_q <= rs1_value_d;
      dn_valid    <= dn_valid_d;
      up_ready    <= up_ready_d;
      up_rd_value <= up_rd_value_d;
      up_error    <= up_error_d;
    end
  end

endmodule

// File: tb/tb_riscv_csrbus_demux.sv
// Scoreboard bench for riscv_csrbus_demux: a driver issues requests and plays
// the targets, pushing the reference-model response into a queue; a monitor
// pops and compares on every up_ready pulse.
module tb_riscv_csrbus_demux;

  localparam int unsigned NCH  = 4;
  localparam int unsigned XL   = 32;
  localparam int          TMO  = 16;

  // Reference decode table (index order); ch3 overlaps ch1 and must never win.
  localparam logic [11:0] M_BASE [NCH] = '{12'h300, 12'hB00, 12'hC00, 12'hB80};
  localparam logic [11:0] M_MASK [NCH] = '{12'hF00, 12'hF00, 12'hF00, 12'hF80};
  localparam logic [NCH-1:0][11:0] P_BASE = {12'hB80, 12'hC00, 12'hB00, 12'h300};
  localparam logic [NCH-1:0][11:0] P_MASK = {12'hF80, 12'hF00, 12'hF00, 12'hF00};

  logic                      clk;
  logic                      rst_n;
  logic                      up_valid;
  logic [2:0]                up_funct3;
  logic [11:0]               up_csr;
  logic [4:0]                up_rs1;
  logic [XL-1:0]             up_rs1_value;
  logic                      up_ready;
  logic [XL-1:0]             up_rd_value;
  logic                      up_error;
  logic [NCH-1:0]            dn_valid;
  logic [2:0]                dn_funct3;
  logic [11:0]               dn_csr;
  logic [4:0]                dn_rs1;
  logic [XL-1:0]             dn_rs1_value;
  logic [NCH-1:0]            dn_ready;
  logic [NCH-1:0][XL-1:0]    dn_rd_value;
  logic [NCH-1:0]            dn_error;

  typedef struct {
    logic [XL-1:0] rd;
    logic          err;
    int            lat;
    longint        issue;
  } exp_t;

  exp_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  riscv_csrbus_demux #(
    .XLEN     (XL),
    .CHANNELS (NCH),
    .BASE     (P_BASE),
    .MASK     (P_MASK),
    .TIMEOUT  (TMO),
    .RO_CHECK (1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .up_valid     (up_valid),
    .up_funct3    (up_funct3),
    .up_csr       (up_csr),
    .up_rs1       (up_rs1),
    .up_rs1_value (up_rs1_value),
    .up_ready     (up_ready),
    .up_rd_value  (up_rd_value),
    .up_error     (up_error),
    .dn_valid     (dn_valid),
    .dn_funct3    (dn_funct3),
    .dn_csr       (dn_csr),
    .dn_rs1       (dn_rs1),
    .dn_rs1_value (dn_rs1_value),
    .dn_ready     (dn_ready),
    .dn_rd_value  (dn_rd_value),
    .dn_error     (dn_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference routing: channel index, or -1 when the access is answered with an error.
  function automatic int model_route(input logic [2:0] f3, input logic [11:0] csr,
                                     input logic [4:0] rs1);
    int  ch;
    bit  wr;
    ch = -1;
    for (int i = int'(NCH) - 1; i >= 0; i--)
      if ((csr & M_MASK[i]) == M_BASE[i]) ch = i;
    if (ch < 0) return -1;
    if (f3 == 3'b000 || f3 == 3'b100) return -1;
    wr = (f3 == 3'b001 || f3 == 3'b101) || (rs1 != 5'd0);
    if (csr >= 12'hC00 && wr) return -1;
    return ch;
  endfunction

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (up_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 64'(up_ready), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("rd_value", 64'(up_rd_value), 64'(e.rd));
          chk("error", 64'(up_error), 64'(e.err));
          chk("latency", 64'(cyc - e.issue), 64'(e.lat));
        end
      end else if (rst_n === 1'b1) begin
        chk("idle_resp_zero", {31'd0, up_error, up_rd_value}, 64'(0));
      end
    end
  end

  task automatic do_txn(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] rs1,
                        input logic [XL-1:0] v, input int wait_c,
                        input logic [XL-1:0] rdata, input logic rerr);
    int   ch;
    int   exp_v;
    int   vcnt;
    int   wrong;
    bit   seen;
    exp_t e;
    ch    = model_route(f3, csr, rs1);
    vcnt  = 0;
    wrong = 0;
    seen  = 1'b0;
    if (ch < 0) begin
      e.rd = '0; e.err = 1'b1; e.lat = 1; exp_v = 0;
    end else if (wait_c < TMO) begin
      e.rd = rdata; e.err = rerr; e.lat = 2 + wait_c; exp_v = wait_c + 1;
    end else begin
      e.rd = '0; e.err = 1'b1; e.lat = TMO + 1; exp_v = TMO;
    end
    @(negedge clk);
    up_valid     = 1'b1;
    up_funct3    = f3;
    up_csr       = csr;
    up_rs1       = rs1;
    up_rs1_value = v;
    e.issue      = cyc;
    sb.push_back(e);
    for (int j = 0; j < 40 && !seen; j++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < int'(NCH); k++)
        if (dn_valid[k]) begin
          if (k == ch) vcnt++;
          else wrong++;
        end
      if (up_ready) begin
        seen     = 1'b1;
        up_valid = 1'b0;
        dn_ready = '0;
      end else begin
        if (ch >= 0 && j == 0)
          chk("payload", {dn_funct3, dn_csr, dn_rs1, dn_rs1_value},
              {f3, csr, rs1, v});
        // Non-selected targets chatter randomly; only the selected one matters.
        dn_ready = NCH'($urandom);
        for (int k = 0; k < int'(NCH); k++) begin
          dn_rd_value[k] = $urandom;
          dn_error[k]    = 1'($urandom);
        end
        if (ch >= 0) begin
          dn_ready[ch]    = (j == wait_c);
          dn_rd_value[ch] = rdata;
          dn_error[ch]    = rerr;
        end
      end
    end
    if (!seen) begin
      chk("response_timeout", 64'(seen), 64'(1));
      up_valid = 1'b0;
      dn_ready = '0;
    end
    chk("valid_cycles", 64'(vcnt), 64'(exp_v));
    chk("stray_valid", 64'(wrong), 64'(0));
    @(posedge clk);
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic reset_mid_fwd();
    @(negedge clk);
    up_valid = 1'b1; up_funct3 = 3'b010; up_csr = 12'h300; up_rs1 = 5'd0;
    up_rs1_value = 32'h5;
    @(posedge clk); #1;
    chk("rst_fwd_valid", 64'(dn_valid), 64'(4'b0001));
    @(negedge clk);
    rst_n    = 1'b0;
    up_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_drop_valid", 64'(dn_valid), 64'(0));
    chk("rst_no_ready", 64'(up_ready), 64'(0));
    @(negedge clk);
    rst_n          = 1'b1;
    dn_ready[0]    = 1'b1;
    dn_rd_value[0] = 32'hDEAD;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_late_ready", {62'd0, up_ready, |dn_valid}, 64'(0));
    end
    dn_ready = '0;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] regions [7];
    logic [11:0] csr;
    logic [4:0]  rs1;
    int          w;
    regions = '{12'h300, 12'hB00, 12'hB80, 12'hC00, 12'h7C0, 12'h000, 12'hF00};

    rst_n = 1'b0; up_valid = 1'b0; up_funct3 = '0; up_csr = '0; up_rs1 = '0;
    up_rs1_value = '0; dn_ready = '0; dn_rd_value = '0; dn_error = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_up", {31'd0, up_ready, up_error, up_rd_value}, 64'(0));
    chk("reset_dn_valid", 64'(dn_valid), 64'(0));
    chk("reset_dn_payload", {dn_funct3, dn_csr, dn_rs1, dn_rs1_value}, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    do_txn(3'b010, 12'h300, 5'd0,  32'h0,      3,   32'h1800,   1'b0);
    do_txn(3'b001, 12'hC00, 5'd5,  32'h1234,   0,   32'hAAAA,   1'b0);
    do_txn(3'b010, 12'hC00, 5'd0,  32'h0,      1,   32'h0C0FFEE, 1'b0);
    do_txn(3'b001, 12'h7C0, 5'd1,  32'h77,     0,   32'h1,      1'b0);
    do_txn(3'b010, 12'hB00, 5'd0,  32'h0,      100, 32'h1,      1'b0);
    do_txn(3'b010, 12'hB00, 5'd0,  32'h0,      15,  32'h4242,   1'b0);
    do_txn(3'b000, 12'h300, 5'd0,  32'h0,      0,   32'h9,      1'b0);
    do_txn(3'b011, 12'hB85, 5'd3,  32'hF0,     2,   32'hB85B85, 1'b1);
    do_txn(3'b110, 12'hC01, 5'd0,  32'h0,      0,   32'h51,     1'b0);
    do_txn(3'b111, 12'hC01, 5'd3,  32'h0,      0,   32'h52,     1'b0);

    reset_mid_fwd();

    for (int n = 0; n < 80; n++) begin
      csr = regions[$urandom_range(0, 6)] | 12'($urandom_range(0, 127));
      rs1 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      w   = ($urandom_range(0, 5) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 6);
      do_txn(3'($urandom), csr, rs1, $urandom, w, $urandom, 1'($urandom));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
